// File: rtl/vga_scanout.sv
// vga_scanout: consumer end of the display pixel FIFO.
// Generates VGA timing (640x480@60 by default) from a pixel clock-enable and pops one
// 24-bit RGB word per active pixel from a first-word-fall-through FIFO. On underflow the
// rest of the frame is blanked, the FIFO is drained during the first blanking line, and the
// producer is asked to restart its frame address.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   pix_ce          pixel clock enable; everything advances only when high
//   fifo_data       FWFT head word {R,G,B}, valid when fifo_empty=0
//   fifo_empty      FIFO empty flag
//   fifo_rd_en      pop strobe (combinational)
//   red/green/blue  registered pixel colour
//   hsync, vsync    registered sync, asserted level SYNC_POL
//   blank           registered, 1 outside active video
//   frame_start     one-clk pulse after the first active pixel of a displayed frame
//   underflow_err   sticky underflow flag, cleared only by rst
//   resync_req      one-clk pulse asking the producer to restart at frame address 0
module vga_scanout #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    input  logic [23:0] fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        frame_start,
    output logic        underflow_err,
    output logic        resync_req
);

    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_S = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_E = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] V_ACT_M1 = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_SYNC_S = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_E = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    localparam logic [1:0] ST_PRIME = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        w_active;
    logic        w_h_last;
    logic        w_underflow;
    logic        w_rd_en;
    logic        w_show;
    logic        w_hs_on;
    logic        w_vs_on;
    logic [23:0] r_rgb;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_blank;
    logic        r_frame_start;
    logic        r_underflow_err;
    logic        r_resync_req;

    always_comb begin
        w_h_last    = (r_h_cnt == H_LAST);
        w_active    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
        w_hs_on     = (r_h_cnt >= H_SYNC_S) && (r_h_cnt < H_SYNC_E);
        w_vs_on     = (r_v_cnt >= V_SYNC_S) && (r_v_cnt < V_SYNC_E);
        w_underflow = pix_ce && w_active && fifo_empty && (r_state == ST_RUN);

        w_rd_en = 1'b0;
        case (r_state)
            ST_RUN:   w_rd_en = pix_ce && w_active && !fifo_empty;
            // Drain whatever the producer left behind during the whole line V_ACTIVE.
            ST_FLUSH: w_rd_en = pix_ce && !fifo_empty;
            default:  w_rd_en = 1'b0;
        endcase
        // Flush pops are discarded; only RUN pops reach the colour outputs.
        w_show = w_rd_en && (r_state == ST_RUN);

        w_state_next = r_state;
        case (r_state)
            ST_PRIME: if (pix_ce && w_h_last && (r_v_cnt == V_LAST)) w_state_next = ST_RUN;
            ST_RUN:   if (w_underflow) w_state_next = ST_DROP;
            ST_DROP:  if (pix_ce && w_h_last && (r_v_cnt == V_ACT_M1)) w_state_next = ST_FLUSH;
            ST_FLUSH: if (pix_ce && w_h_last) w_state_next = ST_PRIME;
            default:  w_state_next = ST_PRIME;
        endcase
    end

    assign fifo_rd_en = w_rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= V_ACT;
            r_state <= ST_PRIME;
        end else if (pix_ce) begin
            r_state <= w_state_next;
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 10'd1;
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb           <= '0;
            r_hsync         <= ~SYNC_POL;
            r_vsync         <= ~SYNC_POL;
            r_blank         <= 1'b1;
            r_frame_start   <= 1'b0;
            r_underflow_err <= 1'b0;
            r_resync_req    <= 1'b0;
        end else begin
            // Pulses update every clk so they last exactly one clk even with sparse pix_ce.
            r_frame_start <= pix_ce && (r_h_cnt == '0) && (r_v_cnt == '0) && (r_state == ST_RUN);
            r_resync_req  <= pix_ce && w_h_last && (r_state == ST_FLUSH);
            if (w_underflow) begin
                r_underflow_err <= 1'b1;
            end
            if (pix_ce) begin
                r_rgb   <= w_show ? fifo_data : 24'h0;
                r_hsync <= w_hs_on ? SYNC_POL : ~SYNC_POL;
                r_vsync <= w_vs_on ? SYNC_POL : ~SYNC_POL;
                r_blank <= ~w_active;
            end
        end
    end

    assign red           = r_rgb[23:16];
    assign green         = r_rgb[15:8];
    assign blue          = r_rgb[7:0];
    assign hsync         = r_hsync;
    assign vsync         = r_vsync;
    assign blank         = r_blank;
    assign frame_start   = r_frame_start;
    assign underflow_err = r_underflow_err;
    assign resync_req    = r_resync_req;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a shrunk raster (16x12 total, 8x6 active) so whole frames
// fit in a short run. Geometry: hsync h in [10,13), vsync v in [8,10), 6 blanking lines
// (v=6..11) before the first frame, 48 pops per frame.
module tb_vga_scanout;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_ce = 1'b1;
    logic [23:0] fifo_data;
    logic        fifo_empty = 1'b0;
    logic        fifo_rd_en;
    logic [7:0]  red, green, blue;
    logic        hsync, vsync, blank, frame_start, underflow_err, resync_req;

    logic [23:0] fifo_word = 24'h102030;

    int n_checks = 0;
    int n_errors = 0;

    int n_pops, n_blank_lo, n_hs_lo, n_vs_lo, n_fs, n_rs, n_data_bad, n_pop_blank;
    int n_ce0_pop, n_hold_bad, n_rgb_nz, fs_idx, rs_idx, hs_idx, vs_idx;

    vga_scanout #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (3),
        .V_ACTIVE (6),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (2),
        .SYNC_POL (1'b0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pix_ce        (pix_ce),
        .fifo_data     (fifo_data),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .red           (red),
        .green         (green),
        .blue          (blue),
        .hsync         (hsync),
        .vsync         (vsync),
        .blank         (blank),
        .frame_start   (frame_start),
        .underflow_err (underflow_err),
        .resync_req    (resync_req)
    );

    always #5 clk = ~clk;

    // FWFT FIFO model: head word advances on each pop.
    assign fifo_data = fifo_word;
    always @(posedge clk) begin
        if (fifo_rd_en) fifo_word <= fifo_word + 24'h010203;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs n pixel periods, each div clks long with pix_ce high on the first clk only.
    // Entered and left at posedge+1. Outputs of pixel k are sampled after its pix_ce edge.
    task automatic run(input int n, input int div, input bit show);
        logic        popped;
        logic [23:0] d;
        logic [26:0] held;
        n_pops = 0; n_blank_lo = 0; n_hs_lo = 0; n_vs_lo = 0; n_fs = 0; n_rs = 0;
        n_data_bad = 0; n_pop_blank = 0; n_ce0_pop = 0; n_hold_bad = 0; n_rgb_nz = 0;
        fs_idx = -1; rs_idx = -1; hs_idx = -1; vs_idx = -1;
        popped = 1'b0; d = '0; held = '0;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < div; j++) begin
                pix_ce = (j == 0);
                #1;
                if (j == 0) begin
                    popped = fifo_rd_en;
                    d      = fifo_data;
                end else if (fifo_rd_en) begin
                    n_ce0_pop++;
                end
                @(posedge clk);
                #1;
                if (j == 0) begin
                    if (popped) n_pops++;
                    if (popped && blank) n_pop_blank++;
                    if (!blank) n_blank_lo++;
                    if (!hsync) begin n_hs_lo++; if (hs_idx < 0) hs_idx = k; end
                    if (!vsync) begin n_vs_lo++; if (vs_idx < 0) vs_idx = k; end
                    if (frame_start) begin n_fs++; if (fs_idx < 0) fs_idx = k; end
                    if (resync_req) begin n_rs++; if (rs_idx < 0) rs_idx = k; end
                    if ({red, green, blue} !== ((popped && show) ? d : 24'h0)) n_data_bad++;
                    if ({red, green, blue} !== 24'h0) n_rgb_nz++;
                    held = {red, green, blue, hsync, vsync, blank};
                end else begin
                    if ({red, green, blue, hsync, vsync, blank} !== held || frame_start
                        || resync_req) n_hold_bad++;
                end
            end
        end
        pix_ce = 1'b1;
    endtask

    initial begin
        // Reset held with pix_ce high and FIFO non-empty.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb", {8'h0, red, green, blue}, 32'h0);
        chk("rst_blank", blank, 1);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_underflow", underflow_err, 0);
        chk("rst_resync", resync_req, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        rst = 1'b0;

        // Six blanking lines in PRIME.
        run(96, 1, 1);
        chk("prime_pops", n_pops, 0);
        chk("prime_blank_lo", n_blank_lo, 0);
        chk("prime_hs_lo", n_hs_lo, 18);
        chk("prime_vs_lo", n_vs_lo, 32);
        chk("prime_fs", n_fs, 0);
        chk("prime_rgb_nz", n_rgb_nz, 0);
        #1;
        chk("first_pop_at_0_0", fifo_rd_en, 1);

        // One full RUN frame.
        run(192, 1, 1);
        chk("f1_pops", n_pops, 48);
        chk("f1_pop_blank", n_pop_blank, 0);
        chk("f1_blank_lo", n_blank_lo, 48);
        chk("f1_hs_lo", n_hs_lo, 36);
        chk("f1_hs_idx", hs_idx, 10);
        chk("f1_vs_lo", n_vs_lo, 32);
        chk("f1_vs_idx", vs_idx, 128);
        chk("f1_fs", n_fs, 1);
        chk("f1_fs_idx", fs_idx, 0);
        chk("f1_rs", n_rs, 0);
        chk("f1_data", n_data_bad, 0);

        // Underflow at pixel (3,2).
        run(35, 1, 1);
        chk("uf_pre_pops", n_pops, 19);
        chk("uf_pre_err", underflow_err, 0);
        fifo_empty = 1'b1;
        run(1, 1, 1);
        fifo_empty = 1'b0;
        chk("uf_pop", n_pops, 0);
        chk("uf_err", underflow_err, 1);
        chk("uf_black", n_rgb_nz, 0);
        chk("uf_blank_lo", blank, 0);
        run(156, 1, 0);
        chk("uf_post_pops", n_pops, 16);
        chk("uf_flush_pops", n_pop_blank, 16);
        chk("uf_post_black", n_rgb_nz, 0);
        chk("uf_post_blank_lo", n_blank_lo, 28);
        chk("uf_rs", n_rs, 1);
        chk("uf_rs_idx", rs_idx, 75);
        chk("uf_fs", n_fs, 0);
        chk("uf_err_sticky", underflow_err, 1);
        #1;
        chk("uf_resume", fifo_rd_en, 1);

        // Full frame with pix_ce 1-in-4.
        run(192, 4, 1);
        chk("ce4_pops", n_pops, 48);
        chk("ce4_ce0_pops", n_ce0_pop, 0);
        chk("ce4_hold", n_hold_bad, 0);
        chk("ce4_blank_lo", n_blank_lo, 48);
        chk("ce4_hs_lo", n_hs_lo, 36);
        chk("ce4_vs_lo", n_vs_lo, 32);
        chk("ce4_fs", n_fs, 1);
        chk("ce4_data", n_data_bad, 0);

        // Reset mid-RUN at pixel (5,3).
        run(53, 1, 1);
        chk("mid_shows_data", (n_rgb_nz != 0), 1);
        chk("mid_blank_lo", blank, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_rgb", {8'h0, red, green, blue}, 32'h0);
        chk("mid_rst_blank", blank, 1);
        chk("mid_rst_err", underflow_err, 0);
        chk("mid_rst_rd_en", fifo_rd_en, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(96, 1, 1);
        chk("mid_prime_pops", n_pops, 0);
        chk("mid_prime_vs_lo", n_vs_lo, 32);
        chk("mid_prime_err", underflow_err, 0);
        #1;
        chk("mid_restart_pop", fifo_rd_en, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
